// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU result type and widths for the ALU stage and its result queue
package alu_pkg;
    localparam int ALU_W     = 4;
    localparam int OVF_CNT_W = 8;
    typedef struct packed {
        logic             overflow;
        logic             zero;
        logic             c;
        logic [ALU_W-1:0] s;
    } alu_result_t;
endpackage

// File: rtl/alu_result_fifo_if.sv
// alu_result_fifo_if: valid/ready bus carrying one ALU result (sum, carry, zero, overflow)
// master drives valid and the result fields; slave drives ready.
interface alu_result_fifo_if #(
    parameter int WIDTH = 4
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             zero;
    logic             overflow;
    modport master(output valid, s, c, zero, overflow, input ready);
    modport slave(input valid, s, c, zero, overflow, output ready);
endinterface

// File: rtl/alu_result_mem.sv
// alu_result_mem: DEPTH x alu_result_t register array, synchronous write with reset, asynchronous read
// Ports: clk, rst (sync, active high); we/waddr/wdata write port; raddr/rdata combinational read port.
module alu_result_mem
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  alu_result_t              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output alu_result_t              rdata
);
    alu_result_t mem [DEPTH];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through queue of ALU results with sticky overflow flag and saturating overflow count
// Ports: clk, rst (sync, active high); in_if (slave) accepts results; out_if (master) presents the head entry;
//        count = occupancy 0..DEPTH; clr_sticky clears sticky_ovf and ovf_cnt; ovf_cnt saturates at 255.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    alu_result_fifo_if.slave             in_if,
    alu_result_fifo_if.master            out_if,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic                         clr_sticky,
    output logic                         sticky_ovf,
    output logic [OVF_CNT_W-1:0]         ovf_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, ovf_push;
    alu_result_t   head;
    // Handshake flags come from registered count only, so no input-to-ready/valid path exists.
    assign in_if.ready  = count != CW'(DEPTH);
    assign out_if.valid = count != '0;
    assign push         = in_if.valid && in_if.ready;
    assign pop          = out_if.valid && out_if.ready;
    assign ovf_push     = push && in_if.overflow;
    alu_result_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({in_if.overflow, in_if.zero, in_if.c, in_if.s}),
        .raddr (rd_ptr),
        .rdata (head)
    );
    assign out_if.s        = head.s;
    assign out_if.c        = head.c;
    assign out_if.zero     = head.zero;
    assign out_if.overflow = head.overflow;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            sticky_ovf <= 1'b0;
            ovf_cnt    <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by plain overflow.
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push != pop) count <= push ? count + CW'(1) : count - CW'(1);
            // A new overflow beats a simultaneous clear.
            sticky_ovf <= ovf_push || (sticky_ovf && !clr_sticky);
            if (clr_sticky) ovf_cnt <= OVF_CNT_W'(ovf_push);
            else if (ovf_push && ovf_cnt != '1) ovf_cnt <= ovf_cnt + OVF_CNT_W'(1);
        end
    end
endmodule
